// File: rtl/cmp_completion_monitor.sv
// Run-control and memory-dump sequencer for the 4-node cardinal CMP.
// Detects the all-NOP completion, flushes, then streams every dmem word out.
module cmp_completion_monitor #(
    parameter int FLUSH_CYCLES = 23,
    parameter int DUMP_DEPTH   = 128,
    parameter int RD_LAT       = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:31] node0_inst_in,
    input  logic [0:31] node1_inst_in,
    input  logic [0:31] node2_inst_in,
    input  logic [0:31] node3_inst_in,
    output logic [0:31] cycle_count,
    output logic        prog_done,
    output logic        dmp_memEn,
    output logic [0:1]  dmp_node_sel,
    output logic [0:7]  dmp_addr,
    input  logic [0:63] dmp_d_in,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [0:1]  dump_node,
    output logic [0:7]  dump_addr,
    output logic [0:63] dump_data,
    output logic        dump_done
);

    typedef enum logic [2:0] {
        S_RUN,
        S_FLUSH,
        S_READ,
        S_WAIT,
        S_HOLD,
        S_DONE
    } state_t;

    localparam logic [0:7]  LAST_ADDR = 8'(DUMP_DEPTH - 1);
    localparam logic [1:0]  LAT_LAST  = 2'(RD_LAT - 1);
    localparam logic [31:0] FLUSH_N   = 32'(FLUSH_CYCLES);

    state_t      state_q;
    logic [0:31] cyc_q;
    logic [31:0] flush_q;
    logic [1:0]  lat_q;
    logic        done_q;
    logic        mem_en_q;
    logic [0:1]  node_q;
    logic [0:7]  addr_q;
    logic        dvalid_q;
    logic [0:1]  dnode_q;
    logic [0:7]  daddr_q;
    logic [0:63] ddata_q;
    logic        dump_done_q;

    logic        all_zero_d;
    logic        flush_last_d;
    logic        last_word_d;
    logic [31:0] flush_inc_d;

    // Completion, flush-end and final-word decodes
    always_comb begin
        all_zero_d = (node0_inst_in == 32'h0) && (node1_inst_in == 32'h0) &&
                     (node2_inst_in == 32'h0) && (node3_inst_in == 32'h0);
        flush_inc_d  = flush_q + 32'd1;
        flush_last_d = (flush_inc_d >= FLUSH_N);
        last_word_d  = (node_q == 2'd3) && (addr_q == LAST_ADDR);
    end

    // Run/flush/dump sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_RUN;
            cyc_q       <= '0;
            flush_q     <= '0;
            lat_q       <= '0;
            done_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            node_q      <= '0;
            addr_q      <= '0;
            dvalid_q    <= 1'b0;
            dnode_q     <= '0;
            daddr_q     <= '0;
            ddata_q     <= '0;
            dump_done_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_RUN: begin
                    if (all_zero_d) begin
                        state_q <= S_FLUSH;
                        done_q  <= 1'b1;
                        flush_q <= '0;
                    end else begin
                        cyc_q <= cyc_q + 32'd1;
                    end
                end
                S_FLUSH: begin
                    if (flush_last_d) begin
                        state_q  <= S_READ;
                        mem_en_q <= 1'b1;
                        node_q   <= '0;
                        addr_q   <= '0;
                    end else begin
                        flush_q <= flush_inc_d;
                    end
                end
                S_READ: begin
                    state_q  <= S_WAIT;
                    mem_en_q <= 1'b0;
                    lat_q    <= '0;
                end
                S_WAIT: begin
                    if (lat_q == LAT_LAST) begin
                        state_q  <= S_HOLD;
                        dvalid_q <= 1'b1;
                        ddata_q  <= dmp_d_in;
                        dnode_q  <= node_q;
                        daddr_q  <= addr_q;
                    end else begin
                        lat_q <= lat_q + 2'd1;
                    end
                end
                S_HOLD: begin
                    if (dvalid_q && dump_ready) begin
                        dvalid_q <= 1'b0;
                        if (node_q == 2'd3) begin
                            node_q <= '0;
                            addr_q <= addr_q + 8'd1;
                        end else begin
                            node_q <= node_q + 2'd1;
                        end
                        if (last_word_d) begin
                            state_q     <= S_DONE;
                            dump_done_q <= 1'b1;
                        end else begin
                            state_q  <= S_READ;
                            mem_en_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_DONE;
                end
                default: begin
                    state_q <= S_RUN;
                end
            endcase
        end
    end

    assign cycle_count  = cyc_q;
    assign prog_done    = done_q;
    assign dmp_memEn    = mem_en_q;
    assign dmp_node_sel = node_q;
    assign dmp_addr     = addr_q;
    assign dump_valid   = dvalid_q;
    assign dump_node    = dnode_q;
    assign dump_addr    = daddr_q;
    assign dump_data    = ddata_q;
    assign dump_done    = dump_done_q;

endmodule

// File: tb/tb_cmp_completion_monitor.sv
// Directed bench for cmp_completion_monitor: default-parameter instance
// plus a FLUSH_CYCLES=0 / RD_LAT=3 / DUMP_DEPTH=4 instance.
module tb_cmp_completion_monitor;

    logic        clk;
    logic        rst_a, rst_b;
    logic [31:0] inst0, inst1, inst2, inst3;
    logic        ready;
    logic        use_b;

    logic [31:0] a_cnt, b_cnt;
    logic        a_pd, b_pd, a_en, b_en, a_valid, b_valid, a_done, b_done;
    logic [1:0]  a_sel, b_sel, a_node, b_node;
    logic [7:0]  a_addr, b_addr, a_daddr, b_daddr;
    logic [63:0] a_din, b_din, a_data, b_data;

    logic        m_valid;
    logic [1:0]  m_node;
    logic [7:0]  m_addr;
    logic [63:0] m_data;

    int checks = 0;
    int failures = 0;

    function automatic logic [63:0] pat(input logic [1:0] n, input logic [7:0] a);
        return {16'hC0DE, 6'd0, n, a, 8'h5A, a ^ 8'hFF, 6'd0, n, 8'h3C};
    endfunction

    cmp_completion_monitor u_a (
        .clk(clk), .reset(rst_a),
        .node0_inst_in(inst0), .node1_inst_in(inst1),
        .node2_inst_in(inst2), .node3_inst_in(inst3),
        .cycle_count(a_cnt), .prog_done(a_pd),
        .dmp_memEn(a_en), .dmp_node_sel(a_sel), .dmp_addr(a_addr),
        .dmp_d_in(a_din),
        .dump_valid(a_valid), .dump_ready(ready),
        .dump_node(a_node), .dump_addr(a_daddr), .dump_data(a_data),
        .dump_done(a_done)
    );

    cmp_completion_monitor #(
        .FLUSH_CYCLES(0), .DUMP_DEPTH(4), .RD_LAT(3)
    ) u_b (
        .clk(clk), .reset(rst_b),
        .node0_inst_in(inst0), .node1_inst_in(inst1),
        .node2_inst_in(inst2), .node3_inst_in(inst3),
        .cycle_count(b_cnt), .prog_done(b_pd),
        .dmp_memEn(b_en), .dmp_node_sel(b_sel), .dmp_addr(b_addr),
        .dmp_d_in(b_din),
        .dump_valid(b_valid), .dump_ready(ready),
        .dump_node(b_node), .dump_addr(b_daddr), .dump_data(b_data),
        .dump_done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: 1-cycle and 3-cycle read pipelines, garbage when idle
    logic [63:0] pa;
    logic [63:0] pb [3];
    always @(posedge clk) begin
        pa    <= a_en ? pat(a_sel, a_addr) : 64'hBAD0_BAD0_BAD0_BAD0;
        pb[0] <= b_en ? pat(b_sel, b_addr) : 64'hBAD1_BAD1_BAD1_BAD1;
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end
    assign a_din = pa;
    assign b_din = pb[2];

    always_comb begin
        m_valid = use_b ? b_valid : a_valid;
        m_node  = use_b ? b_node  : a_node;
        m_addr  = use_b ? b_daddr : a_daddr;
        m_data  = use_b ? b_data  : a_data;
    end

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_run(input int k);
        inst0 = 32'h0000_0013 + 32'(k);
        inst1 = 32'h1000_0000 | 32'(k);
        inst2 = 32'h0020_0000;
        inst3 = 32'h8000_0001;
    endtask

    task automatic set_zero();
        inst0 = 32'h0;
        inst1 = 32'h0;
        inst2 = 32'h0;
        inst3 = 32'h0;
    endtask

    function automatic logic [127:0] a_all();
        return {a_cnt, a_pd, a_en, a_sel, a_addr, a_valid,
                a_node, a_daddr, a_data, a_done};
    endfunction

    // Consume nwords dump words, checking order, stall stability and period
    task automatic drain(input int nwords, input bit rnd, input int period);
        int w = 0;
        int cyc = 0;
        int last = -1;
        bit stalled = 0;
        logic [73:0] saved = '0;
        logic [73:0] cur;
        while (w < nwords && cyc < 30000) begin
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cur = {m_node, m_addr, m_data};
            if (stalled) chk("stall_hold", {m_valid, cur}, {1'b1, saved});
            stalled = 0;
            if (m_valid) begin
                if (ready) begin
                    chk("word", cur, {2'(w % 4), 8'(w / 4),
                                      pat(2'(w % 4), 8'(w / 4))});
                    if (period > 0 && last >= 0)
                        chk("period", 128'(cyc - last), 128'(period));
                    last = cyc;
                    w++;
                end else begin
                    stalled = 1;
                    saved = cur;
                end
            end
            step(1);
            cyc++;
        end
        if (w < nwords) chk("drain_timeout", 128'(w), 128'(nwords));
        ready = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        ready = 1'b0;
        use_b = 1'b0;
        set_run(0);
        step(3);
        chk("reset_a", a_all(), 128'h0);

        // Completion after 100 running cycles
        rst_a = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            set_run(k);
            step(1);
        end
        chk("cnt100", {a_pd, a_cnt}, {1'b0, 32'd100});
        set_zero();
        step(1);
        chk("done_edge", {a_pd, a_cnt, a_en}, {1'b1, 32'd100, 1'b0});
        set_run(7);
        step(22);
        chk("flush_22", {a_en, a_valid}, 2'b00);
        step(1);
        chk("first_rd", {a_en, a_sel, a_addr, a_cnt},
            {1'b1, 2'd0, 8'd0, 32'd100});
        drain(512, 1'b0, 3);
        chk("dump_done", {a_done, a_valid, a_en}, 3'b100);
        step(3);
        chk("done_hold", {a_done, a_pd, a_cnt}, {1'b1, 1'b1, 32'd100});

        // Partial match: nodes 0-2 zero from cycle 10, node 3 at cycle 40
        rst_a = 1'b1;
        step(1);
        chk("reset_a2", a_all(), 128'h0);
        rst_a = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            set_run(k);
            if (k >= 11) begin
                inst0 = 32'h0;
                inst1 = 32'h0;
                inst2 = 32'h0;
            end
            step(1);
        end
        chk("partial", {a_pd, a_cnt}, {1'b0, 32'd40});
        inst3 = 32'h0;
        step(1);
        chk("done40", {a_pd, a_cnt}, {1'b1, 32'd40});

        // Stalled dump, reset at word 200
        set_run(3);
        drain(200, 1'b1, 0);
        chk("frozen40", {a_pd, a_cnt, a_done}, {1'b1, 32'd40, 1'b0});
        rst_a = 1'b1;
        step(1);
        chk("reset_mid", a_all(), 128'h0);
        rst_a = 1'b0;
        step(5);
        chk("cnt_restart", {a_pd, a_cnt}, {1'b0, 32'd5});
        set_zero();
        step(1);
        chk("done5", {a_pd, a_cnt}, {1'b1, 32'd5});
        set_run(9);
        drain(512, 1'b1, 0);
        chk("dump_done2", {a_done, a_valid, a_en, a_cnt},
            {3'b100, 32'd5});

        // Zero flush, 3-cycle read latency, depth 4
        use_b = 1'b1;
        chk("reset_b", {b_cnt, b_pd, b_en, b_valid, b_done, b_data}, 128'h0);
        rst_b = 1'b0;
        set_run(1);
        step(3);
        set_zero();
        step(1);
        chk("b_done_edge", {b_pd, b_en, b_cnt}, {2'b10, 32'd3});
        set_run(2);
        step(1);
        chk("b_first_rd", {b_en, b_sel, b_addr}, {1'b1, 2'd0, 8'd0});
        step(3);
        chk("b_wait", {b_en, b_valid}, 2'b00);
        step(1);
        chk("b_capture", {b_valid, b_data}, {1'b1, pat(2'd0, 8'd0)});
        drain(16, 1'b0, 5);
        chk("b_dump_done", {b_done, b_valid, b_en, b_cnt}, {3'b100, 32'd3});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
